// File: rtl/row_vector_feeder.sv
// Request-side sequencer for the row-by-vector engine: streams row/vector chunk
// pairs out of two synchronous memories and stores each row's dot product.
module row_vector_feeder #(
    parameter int NI            = 8,
    parameter int element_width = 32,
    parameter int ADDR_W        = 12
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [15:0]                   no_of_rows,
    input  logic [31:0]                   no_of_multiples,
    output logic                          a_rd_en,
    output logic [ADDR_W-1:0]             a_rd_addr,
    input  logic [NI*element_width-1:0]   a_rd_data,
    output logic                          p_rd_en,
    output logic [ADDR_W-1:0]             p_rd_addr,
    input  logic [NI*element_width-1:0]   p_rd_data,
    output logic [NI*element_width-1:0]   a,
    output logic [NI*element_width-1:0]   p,
    output logic                          start_row_by_vector,
    output logic                          you_can_read,
    input  logic                          give_me_only,
    input  logic                          I_am_ready,
    input  logic                          decoder_read_now,
    input  logic [element_width-1:0]      result,
    output logic                          res_wr_en,
    output logic [ADDR_W-1:0]             res_wr_addr,
    output logic [element_width-1:0]      res_wr_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, WAIT_RDY, WAIT_REQ, WAIT_RES, DONE
    } state_t;

    state_t                   state_reg, state_next;
    logic [15:0]              rows_reg;
    logic [31:0]              mult_reg;
    logic [15:0]              row_reg;
    logic [31:0]              k_reg;
    logic [ADDR_W-1:0]        base_reg;
    logic                     start_row_reg, you_can_read_reg, res_wr_en_reg, done_reg, err_reg;
    logic [ADDR_W-1:0]        res_wr_addr_reg;
    logic [element_width-1:0] res_wr_data_reg;

    logic [32:0] k_inc;
    logic [16:0] row_inc;
    logic        last_chunk, last_row, zero_count, err_event, fetching;

    assign k_inc      = {1'b0, k_reg} + 33'd1;
    assign row_inc    = {1'b0, row_reg} + 17'd1;
    assign last_chunk = (k_inc == {1'b0, mult_reg});
    assign last_row   = (row_inc == {1'b0, rows_reg});
    assign zero_count = (no_of_rows == 16'd0) || (no_of_multiples == 32'd0);

    // A result strobe is only legal in WAIT_RES; a chunk request only once a row is running.
    assign err_event = (decoder_read_now && (state_reg != WAIT_RES)) ||
                       (give_me_only && ((state_reg == IDLE) || (state_reg == FETCH) ||
                                         (state_reg == LOAD) || (state_reg == WAIT_RDY)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (start) state_next = zero_count ? DONE : FETCH;
            FETCH:    state_next = LOAD;
            LOAD: begin
                if (k_reg == 32'd0)  state_next = WAIT_RDY;
                else if (last_chunk) state_next = WAIT_RES;
                else                 state_next = WAIT_REQ;
            end
            WAIT_RDY: if (I_am_ready) state_next = (mult_reg > 32'd1) ? WAIT_REQ : WAIT_RES;
            WAIT_REQ: if (give_me_only) state_next = FETCH;
            WAIT_RES: if (decoder_read_now) state_next = last_row ? DONE : FETCH;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_reg         <= '0;
            mult_reg         <= '0;
            row_reg          <= '0;
            k_reg            <= '0;
            base_reg         <= '0;
            start_row_reg    <= 1'b0;
            you_can_read_reg <= 1'b0;
            res_wr_en_reg    <= 1'b0;
            res_wr_addr_reg  <= '0;
            res_wr_data_reg  <= '0;
            done_reg         <= 1'b0;
            err_reg          <= 1'b0;
        end else begin
            start_row_reg    <= 1'b0;
            you_can_read_reg <= 1'b0;
            res_wr_en_reg    <= 1'b0;
            done_reg         <= 1'b0;
            case (state_reg)
                IDLE: if (start) begin
                    rows_reg <= no_of_rows;
                    mult_reg <= no_of_multiples;
                    row_reg  <= '0;
                    k_reg    <= '0;
                    base_reg <= '0;
                end
                LOAD: if (k_reg != 32'd0) begin
                    you_can_read_reg <= 1'b1;
                    k_reg            <= k_inc[31:0];
                end
                WAIT_RDY: if (I_am_ready) begin
                    start_row_reg <= 1'b1;
                    k_reg         <= 32'd1;
                end
                WAIT_RES: if (decoder_read_now) begin
                    res_wr_en_reg   <= 1'b1;
                    res_wr_addr_reg <= ADDR_W'(row_reg);
                    res_wr_data_reg <= result;
                    row_reg         <= row_inc[15:0];
                    base_reg        <= base_reg + mult_reg[ADDR_W-1:0];
                    k_reg           <= '0;
                end
                DONE: done_reg <= 1'b1;
                default: ;
            endcase
            if ((state_reg == IDLE) && start) err_reg <= 1'b0;
            else if (err_event)               err_reg <= 1'b1;
        end
    end

    // Chunk lanes are captured only in LOAD, so a/p hold steady across the handshake.
    for (genvar gi = 0; gi < NI; gi++) begin : g_lane
        logic [element_width-1:0] a_lane_reg, p_lane_reg;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                a_lane_reg <= '0;
                p_lane_reg <= '0;
            end else if (state_reg == LOAD) begin
                a_lane_reg <= a_rd_data[gi*element_width +: element_width];
                p_lane_reg <= p_rd_data[gi*element_width +: element_width];
            end
        end
        assign a[gi*element_width +: element_width] = a_lane_reg;
        assign p[gi*element_width +: element_width] = p_lane_reg;
    end

    assign fetching            = (state_reg == FETCH);
    assign a_rd_en             = fetching;
    assign p_rd_en             = fetching;
    assign a_rd_addr           = fetching ? (base_reg + k_reg[ADDR_W-1:0]) : '0;
    assign p_rd_addr           = fetching ? k_reg[ADDR_W-1:0] : '0;
    assign start_row_by_vector = start_row_reg;
    assign you_can_read        = you_can_read_reg;
    assign res_wr_en           = res_wr_en_reg;
    assign res_wr_addr         = res_wr_addr_reg;
    assign res_wr_data         = res_wr_data_reg;
    assign busy                = (state_reg != IDLE);
    assign done                = done_reg;
    assign err                 = err_reg;

endmodule

// File: tb/tb_row_vector_feeder.sv
// Bench for row_vector_feeder: plays memories and engine, checks against an address/data model.
module tb_row_vector_feeder;
    localparam int NI = 8;
    localparam int EW = 32;
    localparam int AW = 12;
    localparam int CW = NI*EW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [15:0]   no_of_rows;
    logic [31:0]   no_of_multiples;
    logic          a_rd_en, p_rd_en;
    logic [AW-1:0] a_rd_addr, p_rd_addr;
    logic [CW-1:0] a_rd_data, p_rd_data;
    logic [CW-1:0] a, p;
    logic          start_row_by_vector, you_can_read;
    logic          give_me_only, I_am_ready, decoder_read_now;
    logic [EW-1:0] result;
    logic          res_wr_en;
    logic [AW-1:0] res_wr_addr;
    logic [EW-1:0] res_wr_data;
    logic          busy, done, err;

    row_vector_feeder #(.NI(NI), .element_width(EW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .no_of_rows(no_of_rows),
        .no_of_multiples(no_of_multiples), .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
        .a_rd_data(a_rd_data), .p_rd_en(p_rd_en), .p_rd_addr(p_rd_addr), .p_rd_data(p_rd_data),
        .a(a), .p(p), .start_row_by_vector(start_row_by_vector), .you_can_read(you_can_read),
        .give_me_only(give_me_only), .I_am_ready(I_am_ready), .decoder_read_now(decoder_read_now),
        .result(result), .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr),
        .res_wr_data(res_wr_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [CW-1:0] a_mem [256];
    logic [CW-1:0] p_mem [256];

    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= a_mem[a_rd_addr[7:0]];
        if (p_rd_en) p_rd_data <= p_mem[p_rd_addr[7:0]];
    end

    int            mon_rd_a[$], mon_rd_p[$];
    bit            mon_kind[$];
    logic [CW-1:0] mon_a[$], mon_p[$];
    int            mon_wr_addr[$];
    logic [EW-1:0] mon_wr_data[$];
    int            mon_done;

    always @(negedge clk) begin
        if (a_rd_en) begin
            mon_rd_a.push_back(int'(a_rd_addr));
            mon_rd_p.push_back(int'(p_rd_addr));
        end
        if (start_row_by_vector || you_can_read) begin
            mon_kind.push_back(start_row_by_vector);
            mon_a.push_back(a);
            mon_p.push_back(p);
        end
        if (res_wr_en) begin
            mon_wr_addr.push_back(int'(res_wr_addr));
            mon_wr_data.push_back(res_wr_data);
        end
        if (done) mon_done++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_rd_a.delete(); mon_rd_p.delete(); mon_kind.delete();
        mon_a.delete(); mon_p.delete(); mon_wr_addr.delete(); mon_wr_data.delete();
        mon_done = 0;
    endtask

    // Drives one full pass as the engine and scores every read, present, write and done.
    task automatic run_pass(input int rows, input int mult, input int rdy_hold, input logic [31:0] fixed_res);
        int cnt, exp_cnt, r, k, total;
        bit seen, stop_pass;
        logic [31:0] res;
        logic [31:0] exp_res[$];
        clear_mon();
        stop_pass  = 0;
        I_am_ready = (rdy_hold == 0);
        no_of_rows = 16'(rows);
        no_of_multiples = 32'(mult);
        start = 1'b1; tick(); start = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear_on_start: got %b want 0", err); end
        for (r = 0; r < rows && !stop_pass; r++) begin
            cnt = 0; seen = 0;
            while (!seen && cnt < 60) begin
                if (r == 0 && rdy_hold > 0 && cnt == rdy_hold) begin
                    n_checks++;
                    if (a !== a_mem[0] || p !== p_mem[0]) begin
                        n_fail++; $display("FAIL ready_hold_chunk: a=%h want %h", a[31:0], a_mem[0][31:0]);
                    end
                    I_am_ready = 1'b1;
                end
                tick(); cnt++;
                seen = start_row_by_vector;
            end
            n_checks++;
            if (!seen) begin
                n_fail++; stop_pass = 1;
                $display("FAIL start_row_timeout: row %0d got no pulse within %0d cycles", r, cnt);
            end else if (r == 0) begin
                exp_cnt = (rdy_hold > 0) ? rdy_hold + 1 : 3;
                n_checks++;
                if (cnt != exp_cnt) begin
                    n_fail++; $display("FAIL start_row_latency: got %0d want %0d", cnt, exp_cnt);
                end
            end
            for (k = 1; k < mult && !stop_pass; k++) begin
                repeat ($urandom_range(0, 2)) tick();
                give_me_only = 1'b1; tick(); give_me_only = 1'b0;
                cnt = 1;
                while (!you_can_read && cnt < 30) begin tick(); cnt++; end
                n_checks++;
                if (you_can_read !== 1'b1 || cnt != 3) begin
                    n_fail++; $display("FAIL you_can_read_latency: row %0d k %0d got %0d want 3", r, k, cnt);
                    if (you_can_read !== 1'b1) stop_pass = 1;
                end
            end
            if (stop_pass) break;
            give_me_only = 1'b1; tick(); give_me_only = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            res = (fixed_res != 32'd0) ? fixed_res : $urandom;
            exp_res.push_back(res);
            result = res; decoder_read_now = 1'b1; tick(); decoder_read_now = 1'b0;
            n_checks++;
            if (res_wr_en !== 1'b1) begin n_fail++; $display("FAIL res_wr_en_pulse: row %0d got %b want 1", r, res_wr_en); end
        end
        cnt = 0;
        while (!done && cnt < 10 && !stop_pass) begin tick(); cnt++; end
        n_checks++;
        if (done !== 1'b1 || cnt != 1) begin n_fail++; $display("FAIL done_timing: done=%b after %0d cycles want 1 after 1", done, cnt); end
        tick(); tick();
        total = rows * mult;
        n_checks++;
        if (mon_rd_a.size() != total) begin n_fail++; $display("FAIL read_count: got %0d want %0d", mon_rd_a.size(), total); end
        for (int i = 0; i < total && i < mon_rd_a.size(); i++) begin
            n_checks++;
            if (mon_rd_a[i] != (i / mult) * mult + (i % mult) || mon_rd_p[i] != i % mult) begin
                n_fail++; $display("FAIL read_addr[%0d]: a=%0d p=%0d want a=%0d p=%0d", i, mon_rd_a[i], mon_rd_p[i], (i / mult) * mult + (i % mult), i % mult);
            end
        end
        n_checks++;
        if (mon_kind.size() != total) begin n_fail++; $display("FAIL present_count: got %0d want %0d", mon_kind.size(), total); end
        for (int i = 0; i < total && i < mon_kind.size(); i++) begin
            n_checks++;
            if (mon_kind[i] != (i % mult == 0) || mon_a[i] !== a_mem[i % 256] || mon_p[i] !== p_mem[i % mult]) begin
                n_fail++; $display("FAIL present[%0d]: kind=%0d a=%h p=%h want kind=%0d a=%h p=%h", i, mon_kind[i], mon_a[i][31:0], mon_p[i][31:0], (i % mult == 0), a_mem[i % 256][31:0], p_mem[i % mult][31:0]);
            end
        end
        n_checks++;
        if (mon_wr_addr.size() != rows) begin n_fail++; $display("FAIL write_count: got %0d want %0d", mon_wr_addr.size(), rows); end
        for (int i = 0; i < rows && i < mon_wr_addr.size() && i < exp_res.size(); i++) begin
            n_checks++;
            if (mon_wr_addr[i] != i || mon_wr_data[i] !== exp_res[i]) begin
                n_fail++; $display("FAIL write[%0d]: addr=%0d data=%h want addr=%0d data=%h", i, mon_wr_addr[i], mon_wr_data[i], i, exp_res[i]);
            end
        end
        n_checks++;
        if (mon_done != 1 || err !== 1'b0) begin n_fail++; $display("FAIL pass_end: done_count=%0d err=%b want 1 and 0", mon_done, err); end
        $display("pass rows=%0d multiples=%0d ready_hold=%0d reads=%0d writes=%0d", rows, mult, rdy_hold, mon_rd_a.size(), mon_wr_addr.size());
        I_am_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; no_of_rows = '0; no_of_multiples = '0;
        give_me_only = 1'b0; I_am_ready = 1'b1; decoder_read_now = 1'b0; result = '0;
        tick(); tick();
        n_checks++;
        if ({a, p} !== '0 || {a_rd_en, p_rd_en, start_row_by_vector, you_can_read, res_wr_en, busy, done, err} !== 8'd0) begin
            n_fail++; $display("FAIL reset_state: outputs not all zero (busy=%b err=%b a=%h)", busy, err, a[31:0]);
        end
        reset = 1'b1; tick();
        $display("reset released");
    endtask

    task automatic test_single_row();
        run_pass(1, 1, 0, 32'h3F80_0000);
    endtask

    task automatic test_three_by_three();
        run_pass(3, 3, 0, 32'd0);
    endtask

    task automatic test_ready_hold();
        run_pass(1, 2, 10, 32'd0);
    endtask

    task automatic test_zero_counts();
        int cnt;
        for (int c = 0; c < 2; c++) begin
            clear_mon();
            no_of_rows = (c == 0) ? 16'd0 : 16'd2;
            no_of_multiples = (c == 0) ? 32'd3 : 32'd0;
            start = 1'b1; tick(); start = 1'b0;
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got %b want 1", busy); end
            cnt = 1;
            while (!done && cnt < 10) begin tick(); cnt++; end
            n_checks++;
            if (done !== 1'b1 || cnt != 2) begin n_fail++; $display("FAIL zero_done: done=%b after %0d want 1 after 2", done, cnt); end
            tick(); tick();
            n_checks++;
            if (mon_rd_a.size() != 0 || mon_wr_addr.size() != 0 || mon_done != 1) begin
                n_fail++; $display("FAIL zero_activity: reads=%0d writes=%0d dones=%0d want 0 0 1", mon_rd_a.size(), mon_wr_addr.size(), mon_done);
            end
            $display("zero-count pass rows=%0d multiples=%0d done_after=%0d", no_of_rows, no_of_multiples, cnt);
        end
    endtask

    task automatic test_reset_mid_row();
        int cnt;
        clear_mon();
        I_am_ready = 1'b1; no_of_rows = 16'd2; no_of_multiples = 32'd4;
        start = 1'b1; tick(); start = 1'b0;
        cnt = 0;
        while (!start_row_by_vector && cnt < 20) begin tick(); cnt++; end
        give_me_only = 1'b1; tick(); give_me_only = 1'b0;
        cnt = 0;
        while (!you_can_read && cnt < 20) begin tick(); cnt++; end
        n_checks++;
        if (you_can_read !== 1'b1 || a === '0) begin n_fail++; $display("FAIL midrow_setup: ycr=%b a=%h", you_can_read, a[31:0]); end
        reset = 1'b0; #1;
        n_checks++;
        if ({a, p} !== '0 || {a_rd_addr, p_rd_addr, res_wr_addr, res_wr_data} !== '0 ||
            {a_rd_en, p_rd_en, start_row_by_vector, you_can_read, res_wr_en, busy, done, err} !== 8'd0) begin
            n_fail++; $display("FAIL midrow_reset_outputs: busy=%b ycr=%b a=%h want all zero", busy, you_can_read, a[31:0]);
        end
        tick(); tick(); reset = 1'b1;
        clear_mon();
        for (int i = 0; i < 20; i++) begin
            decoder_read_now = (i == 3) ? 1'b1 : 1'($urandom_range(0, 1));
            give_me_only = 1'($urandom_range(0, 1));
            result = $urandom;
            tick();
        end
        decoder_read_now = 1'b0; give_me_only = 1'b0; tick();
        n_checks++;
        if (mon_wr_addr.size() != 0 || mon_rd_a.size() != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: writes=%0d reads=%0d busy=%b want 0 0 0", mon_wr_addr.size(), mon_rd_a.size(), busy);
        end
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL idle_strobe_err: got %b want 1", err); end
        $display("mid-row reset: writes after release=%0d err=%b", mon_wr_addr.size(), err);
    endtask

    task automatic test_err();
        int cnt;
        logic [31:0] res;
        clear_mon();
        I_am_ready = 1'b1; no_of_rows = 16'd1; no_of_multiples = 32'd3;
        start = 1'b1; tick(); start = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", err); end
        cnt = 0;
        while (!start_row_by_vector && cnt < 20) begin tick(); cnt++; end
        result = 32'hDEAD_BEEF; decoder_read_now = 1'b1; tick(); decoder_read_now = 1'b0;
        n_checks++;
        if (err !== 1'b1 || res_wr_en !== 1'b0) begin n_fail++; $display("FAIL strobe_in_wait_req: err=%b wr=%b want 1 0", err, res_wr_en); end
        for (int k = 1; k < 3; k++) begin
            give_me_only = 1'b1; tick(); give_me_only = 1'b0;
            cnt = 0;
            while (!you_can_read && cnt < 20) begin tick(); cnt++; end
        end
        res = $urandom; result = res; decoder_read_now = 1'b1; tick(); decoder_read_now = 1'b0;
        n_checks++;
        if (res_wr_en !== 1'b1 || res_wr_data !== res || res_wr_addr !== '0) begin
            n_fail++; $display("FAIL err_pass_write: wr=%b data=%h addr=%0d want 1 %h 0", res_wr_en, res_wr_data, res_wr_addr, res);
        end
        cnt = 0;
        while (!done && cnt < 10) begin tick(); cnt++; end
        tick();
        n_checks++;
        if (mon_wr_addr.size() != 1 || err !== 1'b1 || mon_done != 1) begin
            n_fail++; $display("FAIL err_sticky: writes=%0d err=%b dones=%0d want 1 1 1", mon_wr_addr.size(), err, mon_done);
        end
        $display("err pass: err=%b writes=%0d", err, mon_wr_addr.size());
    endtask

    task automatic test_random();
        int rows, mult, hold;
        for (int n = 0; n < 6; n++) begin
            rows = $urandom_range(1, 4);
            mult = $urandom_range(1, 5);
            hold = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 6)) : 0;
            run_pass(rows, mult, hold, 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < NI; j++) begin
                a_mem[i][j*EW +: EW] = $urandom;
                p_mem[i][j*EW +: EW] = $urandom;
            end
        end
        test_reset();
        test_single_row();
        test_three_by_three();
        test_ready_hold();
        test_zero_counts();
        test_reset_mid_row();
        test_err();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
